// File: rtl/tdm_frame_rx.sv
// Serial TDM receiver: recovers frame alignment from an embedded sync word and deserialises one data byte per frame.
// Optional even-parity bit after each data byte when TDM_RX_PARITY_EN is defined (adds the parity_err port).
module tdm_frame_rx #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned LOSS_CNT  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_en,
  output logic [7:0] led,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err
`ifdef TDM_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
`ifdef TDM_RX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd3;
`endif

  localparam logic [2:0] LOCK_CNT_L = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_CNT_L = 3'(LOSS_CNT);

  logic [1:0] state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] good_cnt_q, good_cnt_d;
  logic [2:0] bad_cnt_q, bad_cnt_d;
  logic       locked_q, locked_d;
  logic [7:0] led_q, led_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;
`ifdef TDM_RX_PARITY_EN
  logic       parity_err_q, parity_err_d;
`endif

  logic [7:0] sr_shift;
  logic [7:0] byte_next;
  logic [2:0] good_inc;
  logic [2:0] bad_inc;

  always_comb begin
    sr_shift             = {sin, sr_q[7:1]};
    byte_next            = byte_q;
    byte_next[bit_cnt_q] = sin;
    good_inc             = (good_cnt_q == 3'd7) ? 3'd7 : good_cnt_q + 3'd1;
    bad_inc              = (bad_cnt_q == 3'd7) ? 3'd7 : bad_cnt_q + 3'd1;

    state_d       = state_q;
    sr_d          = sr_q;
    byte_d        = byte_q;
    bit_cnt_d     = bit_cnt_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    locked_d      = locked_q;
    led_d         = led_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef TDM_RX_PARITY_EN
    parity_err_d  = 1'b0;
`endif

    if (sin_en) begin
      case (state_q)
        ST_HUNT: begin
          sr_d = sr_shift;
          if (sr_shift == SYNC_WORD) begin
            good_cnt_d = 3'd1;
            bad_cnt_d  = 3'd0;
            bit_cnt_d  = 3'd0;
            state_d    = ST_DATA;
            if (LOCK_CNT_L == 3'd1) begin
              locked_d = 1'b1;
            end
          end
        end

        ST_DATA: begin
          byte_d    = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef TDM_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            // Bytes received before lock are dropped silently.
            if (locked_q) begin
              led_d         = byte_next;
              frame_valid_d = 1'b1;
            end
            state_d = ST_SYNC;
`endif
          end
        end

`ifdef TDM_RX_PARITY_EN
        ST_PARITY: begin
          if (sin == ^byte_q) begin
            if (locked_q) begin
              led_d         = byte_q;
              frame_valid_d = 1'b1;
            end
          end else begin
            parity_err_d = 1'b1;
          end
          bit_cnt_d = 3'd0;
          state_d   = ST_SYNC;
        end
`endif

        ST_SYNC: begin
          sr_d      = sr_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (sr_shift == SYNC_WORD) begin
              good_cnt_d = good_inc;
              bad_cnt_d  = 3'd0;
              if (good_inc >= LOCK_CNT_L) begin
                locked_d = 1'b1;
              end
              state_d = ST_DATA;
            end else begin
              sync_err_d = 1'b1;
              good_cnt_d = 3'd0;
              if (!locked_q) begin
                bad_cnt_d = bad_inc;
                state_d   = ST_HUNT;
              end else if (bad_inc >= LOSS_CNT_L) begin
                locked_d  = 1'b0;
                bad_cnt_d = 3'd0;
                state_d   = ST_HUNT;
              end else begin
                // Flywheel: tolerate an isolated bad sync and keep alignment.
                bad_cnt_d = bad_inc;
                state_d   = ST_DATA;
              end
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      sr_q          <= 8'h00;
      byte_q        <= 8'h00;
      bit_cnt_q     <= 3'd0;
      good_cnt_q    <= 3'd0;
      bad_cnt_q     <= 3'd0;
      locked_q      <= 1'b0;
      led_q         <= 8'h00;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      byte_q        <= byte_d;
      bit_cnt_q     <= bit_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      locked_q      <= locked_d;
      led_q         <= led_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
`ifdef TDM_RX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign led         = led_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
`ifdef TDM_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
